// File: rtl/xdatabus_responder.sv
// Databus responder: round-robin arbitration of N_PORTS masters onto one req/ack backend port.
// Latency: valid edge -> m_req next cycle; ack edge -> ready pulse next cycle; backend stalls hold m_* stable.
module xdatabus_responder #(
  parameter int N_PORTS   = 2,
  parameter int DATABUS_W = 256,
  parameter int ADDR_W    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_PORTS-1:0]             databus_valid,
  input  logic [N_PORTS*ADDR_W-1:0]      databus_addr,
  input  logic [N_PORTS*DATABUS_W-1:0]   databus_wdata,
  input  logic [N_PORTS*DATABUS_W/8-1:0] databus_wstrb,
  output logic [N_PORTS-1:0]             databus_ready,
  output logic [N_PORTS*DATABUS_W-1:0]   databus_rdata,
  output logic                           m_req,
  output logic                           m_we,
  output logic [ADDR_W-1:0]              m_addr,
  output logic [DATABUS_W-1:0]           m_wdata,
  output logic [DATABUS_W/8-1:0]         m_wstrb,
  input  logic                           m_ack,
  input  logic [DATABUS_W-1:0]           m_rdata
);

  localparam int STRB_W = DATABUS_W / 8;
  localparam int PTR_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [DATABUS_W-1:0] wdata;
    logic [STRB_W-1:0]    wstrb;
  } cmd_t;

  state_t               state, state_nxt;
  cmd_t                 cmd_q, cmd_nxt;
  logic                 req_q, req_nxt;
  logic                 we_q, we_nxt;
  logic [N_PORTS-1:0]   rdy_q, rdy_nxt;
  logic [DATABUS_W-1:0] rdata_q, rdata_nxt;
  logic [PTR_W-1:0]     rr_ptr, rr_nxt;
  logic [PTR_W-1:0]     grant, grant_nxt;
  logic                 pick_vld;
  logic [PTR_W-1:0]     pick_idx;
  int                   scan_idx;

  // Scan from rr_ptr downwards in offset so the smallest offset wins last.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = 0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      scan_idx = (int'(rr_ptr) + i) % N_PORTS;
      if (databus_valid[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = PTR_W'(scan_idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd_q;
    req_nxt   = req_q;
    we_nxt    = we_q;
    rdy_nxt   = '0;
    rdata_nxt = rdata_q;
    rr_nxt    = rr_ptr;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_nxt     = pick_idx;
          cmd_nxt.addr  = databus_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          cmd_nxt.wdata = databus_wdata[int'(pick_idx)*DATABUS_W +: DATABUS_W];
          cmd_nxt.wstrb = databus_wstrb[int'(pick_idx)*STRB_W +: STRB_W];
          we_nxt        = |databus_wstrb[int'(pick_idx)*STRB_W +: STRB_W];
          req_nxt       = 1'b1;
          state_nxt     = REQ;
        end
      end
      REQ: begin
        if (m_ack) begin
          req_nxt = 1'b0;
          if (!we_q) rdata_nxt = m_rdata;
          rdy_nxt[grant] = 1'b1;
          state_nxt      = RESP;
        end
      end
      RESP: begin
        if (int'(grant) == N_PORTS - 1) rr_nxt = '0;
        else                            rr_nxt = grant + 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset abandons any in-flight transaction; a late ack then lands in IDLE and is ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cmd_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      rdy_q   <= '0;
      rdata_q <= '0;
      rr_ptr  <= '0;
      grant   <= '0;
    end else begin
      state   <= state_nxt;
      cmd_q   <= cmd_nxt;
      req_q   <= req_nxt;
      we_q    <= we_nxt;
      rdy_q   <= rdy_nxt;
      rdata_q <= rdata_nxt;
      rr_ptr  <= rr_nxt;
      grant   <= grant_nxt;
    end
  end

  assign m_req         = req_q;
  assign m_we          = we_q;
  assign m_addr        = cmd_q.addr;
  assign m_wdata       = cmd_q.wdata;
  assign m_wstrb       = cmd_q.wstrb;
  assign databus_ready = rdy_q;
  assign databus_rdata = {N_PORTS{rdata_q}};

endmodule

// File: tb/tb_xdatabus_responder.sv
// Directed bench for xdatabus_responder: per-cycle vector table plus contention and backpressure sequences.
module tb_xdatabus_responder;

  localparam int NP = 2;
  localparam int DW = 256;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   vld;
  logic [AW-1:0]   a0, a1;
  logic [DW-1:0]   wd0, wd1;
  logic [SW-1:0]   s0, s1;
  logic [NP-1:0]   ready;
  logic [NP*DW-1:0] rdata_all;
  logic            m_req, m_we, m_ack;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata, m_rdata;
  logic [SW-1:0]   m_wstrb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  xdatabus_responder #(.N_PORTS(NP), .DATABUS_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .databus_valid(vld), .databus_addr({a1, a0}), .databus_wdata({wd1, wd0}),
    .databus_wstrb({s1, s0}), .databus_ready(ready), .databus_rdata(rdata_all),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  typedef struct {
    string         nm;
    logic          r;
    logic [1:0]    v;
    logic [AW-1:0] a0, a1;
    logic [SW-1:0] s0, s1;
    logic          ack;
    logic [DW-1:0] rd;
    logic [1:0]    e_rdy;
    logic          e_req, e_we;
    logic [AW-1:0] e_addr;
    logic [SW-1:0] e_wstrb;
    logic [DW-1:0] e_wdata, e_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(string nm, logic r, logic [1:0] v, logic [AW-1:0] xa0, logic [SW-1:0] xs0,
                              logic [AW-1:0] xa1, logic [SW-1:0] xs1, logic ack, logic [DW-1:0] rd,
                              logic [1:0] e_rdy, logic e_req, logic e_we, logic [AW-1:0] e_addr,
                              logic [SW-1:0] e_wstrb, logic [DW-1:0] e_wdata, logic [DW-1:0] e_rdata);
    vec_t t;
    t.nm = nm; t.r = r; t.v = v; t.a0 = xa0; t.s0 = xs0; t.a1 = xa1; t.s1 = xs1;
    t.ack = ack; t.rd = rd; t.e_rdy = e_rdy; t.e_req = e_req; t.e_we = e_we;
    t.e_addr = e_addr; t.e_wstrb = e_wstrb; t.e_wdata = e_wdata; t.e_rdata = e_rdata;
    return t;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[20];
    logic [DW-1:0] A5, X77, X33, X5A, XC3, X96, Z;
    int n0, n1, done, last, cyc, exp_p, hi;

    A5 = {32{8'hA5}}; X77 = {32{8'h77}}; X33 = {32{8'h33}}; X5A = {32{8'h5A}};
    XC3 = {32{8'hC3}}; X96 = {32{8'h96}}; Z = '0;
    wd0 = {32{8'h5E}}; wd1 = {16{16'h1234}};
    rst = 1'b0; vld = '0; a0 = '0; a1 = '0; s0 = '0; s1 = '0; m_ack = 1'b0; m_rdata = '0;

    //           name          r  v      a0       s0            a1       s1            ack rd   rdy    req we addr     wstrb         wdata rdata
    vt[0]  = mk("reset",       0, 2'b00, 32'h0,   32'h0,        32'h0,   32'h0,        0, Z,   2'b00, 0, 0, 32'h0,   32'h0,        Z,   Z);
    vt[1]  = mk("rd_req",      1, 2'b01, 32'h40,  32'h0,        32'h0,   32'h0,        0, Z,   2'b00, 1, 0, 32'h40,  32'h0,        wd0, Z);
    vt[2]  = mk("rd_ack",      1, 2'b01, 32'h40,  32'h0,        32'h0,   32'h0,        1, A5,  2'b01, 0, 0, 32'h40,  32'h0,        wd0, A5);
    vt[3]  = mk("rd_done",     1, 2'b00, 32'h40,  32'h0,        32'h0,   32'h0,        0, Z,   2'b00, 0, 0, 32'h40,  32'h0,        wd0, A5);
    vt[4]  = mk("wr_req",      1, 2'b10, 32'h0,   32'h0,        32'h80,  32'h0000FFFF, 0, Z,   2'b00, 1, 1, 32'h80,  32'h0000FFFF, wd1, A5);
    vt[5]  = mk("wr_ack",      1, 2'b10, 32'h0,   32'h0,        32'h80,  32'h0000FFFF, 1, X77, 2'b10, 0, 1, 32'h80,  32'h0000FFFF, wd1, A5);
    vt[6]  = mk("wr_done",     1, 2'b00, 32'h0,   32'h0,        32'h80,  32'h0000FFFF, 0, Z,   2'b00, 0, 1, 32'h80,  32'h0000FFFF, wd1, A5);
    vt[7]  = mk("stray_ack",   1, 2'b00, 32'h0,   32'h0,        32'h80,  32'h0000FFFF, 1, X33, 2'b00, 0, 1, 32'h80,  32'h0000FFFF, wd1, A5);
    vt[8]  = mk("both_p0",     1, 2'b11, 32'h100, 32'h0,        32'h180, 32'hF,        0, Z,   2'b00, 1, 0, 32'h100, 32'h0,        wd0, A5);
    vt[9]  = mk("both_p0_ack", 1, 2'b11, 32'h100, 32'h0,        32'h180, 32'hF,        1, X5A, 2'b01, 0, 0, 32'h100, 32'h0,        wd0, X5A);
    vt[10] = mk("both_resp",   1, 2'b10, 32'h100, 32'h0,        32'h180, 32'hF,        0, Z,   2'b00, 0, 0, 32'h100, 32'h0,        wd0, X5A);
    vt[11] = mk("p1_req",      1, 2'b10, 32'h100, 32'h0,        32'h180, 32'hF,        0, Z,   2'b00, 1, 1, 32'h180, 32'hF,        wd1, X5A);
    vt[12] = mk("rst_mid",     0, 2'b10, 32'h100, 32'h0,        32'h180, 32'hF,        1, X33, 2'b00, 0, 0, 32'h0,   32'h0,        Z,   Z);
    vt[13] = mk("late_ack",    1, 2'b00, 32'h100, 32'h0,        32'h180, 32'hF,        1, X33, 2'b00, 0, 0, 32'h0,   32'h0,        Z,   Z);
    vt[14] = mk("post_rst_p0", 1, 2'b11, 32'h300, 32'h0,        32'h380, 32'hF,        0, Z,   2'b00, 1, 0, 32'h300, 32'h0,        wd0, Z);
    vt[15] = mk("post_p0_ack", 1, 2'b11, 32'h300, 32'h0,        32'h380, 32'hF,        1, XC3, 2'b01, 0, 0, 32'h300, 32'h0,        wd0, XC3);
    vt[16] = mk("post_resp",   1, 2'b10, 32'h300, 32'h0,        32'h380, 32'hF,        0, Z,   2'b00, 0, 0, 32'h300, 32'h0,        wd0, XC3);
    vt[17] = mk("post_p1",     1, 2'b10, 32'h300, 32'h0,        32'h380, 32'hF,        0, Z,   2'b00, 1, 1, 32'h380, 32'hF,        wd1, XC3);
    vt[18] = mk("post_p1_ack", 1, 2'b10, 32'h300, 32'h0,        32'h380, 32'hF,        1, X77, 2'b10, 0, 1, 32'h380, 32'hF,        wd1, XC3);
    vt[19] = mk("post_done",   1, 2'b00, 32'h300, 32'h0,        32'h380, 32'hF,        0, Z,   2'b00, 0, 1, 32'h380, 32'hF,        wd1, XC3);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rst = vt[i].r; vld = vt[i].v; a0 = vt[i].a0; a1 = vt[i].a1; s0 = vt[i].s0; s1 = vt[i].s1;
      m_ack = vt[i].ack; m_rdata = vt[i].rd;
      @(posedge clk); #1;
      chk({vt[i].nm, ".ready"}, ready, vt[i].e_rdy);
      chk({vt[i].nm, ".m_req"}, m_req, vt[i].e_req);
      chk({vt[i].nm, ".m_we"}, m_we, vt[i].e_we);
      chk({vt[i].nm, ".m_addr"}, m_addr, vt[i].e_addr);
      chk({vt[i].nm, ".m_wstrb"}, m_wstrb, vt[i].e_wstrb);
      chk({vt[i].nm, ".m_wdata"}, m_wdata, vt[i].e_wdata);
      chk({vt[i].nm, ".rdata0"}, rdata_all[DW-1:0], vt[i].e_rdata);
      chk({vt[i].nm, ".rdata1"}, rdata_all[2*DW-1:DW], vt[i].e_rdata);
    end

    // Contention: both ports keep requesting, ack always high -> alternating grants every 3 cycles.
    a0 = 32'h400; a1 = 32'h480; s0 = '0; s1 = '0; m_ack = 1'b1; m_rdata = X96;
    n0 = 0; n1 = 0; done = 0; last = -1; cyc = 0;
    while (done < 8 && cyc < 40) begin
      @(negedge clk);
      vld = {n1 < 4, n0 < 4};
      @(posedge clk); #1;
      cyc++;
      if (|ready) begin
        exp_p = done % 2;
        chk("cont_order", ready, 2'b01 << exp_p);
        chk("cont_addr", m_addr, (exp_p == 1) ? 32'h480 : 32'h400);
        if (last >= 0) chk("cont_spacing", cyc - last, 3);
        else           chk("cont_first", cyc, 2);
        last = cyc;
        done++;
        if (ready[0]) n0++;
        if (ready[1]) n1++;
      end
    end
    chk("cont_count", done, 8);
    chk("cont_rdata", rdata_all[DW-1:0], X96);
    @(negedge clk);
    vld = '0; m_ack = 1'b0;
    @(posedge clk); #1;

    // Backpressure: write held in REQ for 6 cycles before ack.
    @(negedge clk);
    vld = 2'b01; a0 = 32'h500; s0 = 32'hFF0000FF; m_ack = 1'b0;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (m_req) hi++;
      chk("bp_addr", m_addr, 32'h500);
      chk("bp_ready", ready, 2'b00);
    end
    chk("bp_req_cycles", hi, 6);
    chk("bp_we", m_we, 1'b1);
    chk("bp_wstrb", m_wstrb, 32'hFF0000FF);
    @(negedge clk);
    m_ack = 1'b1; m_rdata = X33;
    @(posedge clk); #1;
    chk("bp_ready_pulse", ready, 2'b01);
    chk("bp_req_drop", m_req, 1'b0);
    @(negedge clk);
    m_ack = 1'b0; vld = '0;
    @(posedge clk); #1;
    chk("bp_ready_end", ready, 2'b00);
    chk("bp_rdata_kept", rdata_all[DW-1:0], X96);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
